// File: rtl/coherent_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// coherent_bus_arbiter: N-core snooping bus controller and shared RAM arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
module coherent_bus_arbiter #(
  parameter int CPUS = 2,
  parameter int WPB  = 2
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [CPUS-1:0]    iREN,
  input  logic [CPUS*32-1:0] iaddr,
  output logic [CPUS-1:0]    iwait,
  output logic [CPUS*32-1:0] iload,
  input  logic [CPUS-1:0]    dREN,
  input  logic [CPUS-1:0]    dWEN,
  input  logic [CPUS*32-1:0] daddr,
  input  logic [CPUS*32-1:0] dstore,
  output logic [CPUS-1:0]    dwait,
  output logic [CPUS*32-1:0] dload,
  input  logic [CPUS-1:0]    ccwrite,
  input  logic [CPUS-1:0]    cctrans,
  output logic [CPUS-1:0]    ccwait,
  output logic [CPUS-1:0]    ccinv,
  output logic [CPUS*32-1:0] ccsnoopaddr,
  output logic [31:0]        ramaddr,
  output logic [31:0]        ramstore,
  output logic               ramREN,
  output logic               ramWEN,
  input  logic [1:0]         ramstate,
  input  logic [31:0]        ramload
);

  localparam int IW  = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int BW  = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int OFF = $clog2(WPB) + 2;
  localparam logic [1:0] ACCESS = 2'b10;

  typedef enum logic [2:0] {IDLE, ARB, SNOOP, SHARE, FILL, WB} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   d_rr, i_rr, grant, supp;
  logic [BW-1:0]   beat;
  logic            lk_ccw;
  logic [31:0]     lk_addr;

  logic            access, last, ram_free, i_active, snoop_ack, snoop_done;
  logic            d_found, i_found, s_found;
  logic [IW-1:0]   d_pick, i_pick, s_pick;
  logic [CPUS-1:0] others;
  logic [31:0]     blk_addr;

  // First requester at or after ptr, wrapping; MSB flags that one was found.
  function automatic logic [IW:0] rr_pick(input logic [CPUS-1:0] req, input logic [IW-1:0] ptr);
    logic [IW:0] r;
    int idx;
    r = '0;
    for (int k = CPUS - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % CPUS;
      if (req[idx]) r = {1'b1, IW'(idx)};
    end
    return r;
  endfunction

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] p);
    return (int'(p) == CPUS - 1) ? '0 : p + 1'b1;
  endfunction

  assign access   = (ramstate == ACCESS);
  assign last     = access && (beat == BW'(WPB - 1));
  assign ram_free = (state == IDLE) || (state == ARB) || (state == SNOOP);
  assign {d_found, d_pick} = rr_pick(dREN | dWEN, d_rr);
  assign {i_found, i_pick} = rr_pick(iREN, i_rr);
  assign others   = ~(CPUS'(1) << grant);
  assign {s_found, s_pick} = rr_pick(ccwrite & others, '0);
  assign i_active = ram_free && i_found;
  assign snoop_ack = &(cctrans | ~others);
  // An in-flight icache beat finishes before the data transfer takes the RAM.
  assign snoop_done = snoop_ack && (!i_active || access);
  assign blk_addr = {lk_addr[31:OFF], {OFF{1'b0}}} + (32'(beat) << 2);

  always_comb begin
    state_nxt   = state;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    iwait       = '1;
    dwait       = '1;
    ccwait      = '0;
    ccinv       = '0;
    iload       = {CPUS{ramload}};
    dload       = {CPUS{ramload}};
    ccsnoopaddr = {CPUS{lk_addr}};
    if (i_active) begin
      ramREN        = 1'b1;
      ramaddr       = iaddr[int'(i_pick)*32 +: 32];
      iwait[i_pick] = ~access;
    end
    case (state)
      IDLE: if (|(dREN | dWEN)) state_nxt = ARB;
      ARB: begin
        if (!d_found)            state_nxt = IDLE;
        else if (dWEN[d_pick])   state_nxt = WB;
        else                     state_nxt = SNOOP;
      end
      SNOOP: begin
        ccwait = others;
        if (snoop_done) begin
          state_nxt = s_found ? SHARE : FILL;
          if (lk_ccw) ccinv = others;
        end
      end
      SHARE: begin
        ramWEN                       = 1'b1;
        ramaddr                      = blk_addr;
        ramstore                     = dstore[int'(supp)*32 +: 32];
        dload[int'(grant)*32 +: 32]  = dstore[int'(supp)*32 +: 32];
        ccwait[supp]                 = 1'b1;
        dwait[grant]                 = ~access;
        dwait[supp]                  = ~access;
        if (last) state_nxt = IDLE;
      end
      FILL: begin
        ramREN       = 1'b1;
        ramaddr      = blk_addr;
        dwait[grant] = ~access;
        if (last) state_nxt = IDLE;
      end
      WB: begin
        ramWEN       = 1'b1;
        ramaddr      = blk_addr;
        ramstore     = dstore[int'(grant)*32 +: 32];
        dwait[grant] = ~access;
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      d_rr    <= '0;
      i_rr    <= '0;
      grant   <= '0;
      supp    <= '0;
      beat    <= '0;
      lk_ccw  <= 1'b0;
      lk_addr <= '0;
    end else begin
      state <= state_nxt;
      if (i_active && access) i_rr <= nxt(i_pick);
      if (state == ARB && d_found) begin
        grant   <= d_pick;
        lk_ccw  <= ccwrite[d_pick];
        lk_addr <= daddr[int'(d_pick)*32 +: 32];
        d_rr    <= nxt(d_pick);
      end
      if (state == SNOOP && snoop_done) supp <= s_pick;
      if ((state == SHARE || state == FILL || state == WB) && access)
        beat <= last ? '0 : beat + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_coherent_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_coherent_bus_arbiter: random traffic against a transaction-level model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_coherent_bus_arbiter;
  localparam int CPUS = 4;
  localparam int WPB  = 4;
  localparam logic [1:0] ACC = 2'd2;

  logic CLK = 1'b0;
  logic nRST;
  logic [CPUS-1:0]    iREN, iwait, dREN, dWEN, dwait, ccwrite, cctrans, ccwait, ccinv;
  logic [CPUS*32-1:0] iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
  logic [31:0]        ramaddr, ramstore, ramload;
  logic               ramREN, ramWEN;
  logic [1:0]         ramstate;

  always #5 CLK = ~CLK;

  coherent_bus_arbiter #(.CPUS(CPUS), .WPB(WPB)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ccwrite(ccwrite), .cctrans(cctrans), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramstate(ramstate), .ramload(ramload)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Outstanding cache requests, held until their block transfer completes.
  bit          rq_rd[CPUS], rq_wr[CPUS], rq_ccw[CPUS];
  logic [31:0] rq_addr[CPUS];

  // Transaction-level view: owner of the bus, what it is doing, words left.
  int          m_owner, m_src, m_words, m_drr, m_irr;
  bit          m_arb, m_snoop, m_write, m_rdx;
  logic [31:0] m_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [CPUS-1:0] v, input int start);
    for (int k = 0; k < CPUS; k++)
      if (v[(start + k) % CPUS]) return (start + k) % CPUS;
    return -1;
  endfunction

  function automatic bit snoop_ok(input int ic, input bit acc);
    for (int k = 0; k < CPUS; k++)
      if (k != m_owner && !cctrans[k]) return 1'b0;
    return (ic < 0) || acc;
  endfunction

  task automatic model_reset;
    m_owner = -1; m_src = -1; m_words = 0; m_drr = 0; m_irr = 0;
    m_arb = 0; m_snoop = 0; m_write = 0; m_rdx = 0; m_addr = '0;
    for (int c = 0; c < CPUS; c++) begin
      rq_rd[c] = 0; rq_wr[c] = 0; rq_ccw[c] = 0; rq_addr[c] = '0;
    end
  endtask

  task automatic drive_zero;
    iREN = '0; iaddr = '0; dREN = '0; dWEN = '0; daddr = '0; dstore = '0;
    ccwrite = '0; cctrans = '0; ramstate = 2'd0; ramload = '0;
  endtask

  task automatic drive_random;
    for (int c = 0; c < CPUS; c++) begin
      if (!rq_rd[c] && !rq_wr[c] && $urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0: rq_rd[c] = 1;
          1: rq_wr[c] = 1;
          default: begin rq_rd[c] = 1; rq_wr[c] = 1; end
        endcase
        rq_addr[c] = $urandom & 32'h0000_FFFC;
        rq_ccw[c]  = 1'($urandom_range(0, 1));
      end
      dREN[c] = rq_rd[c];
      dWEN[c] = rq_wr[c];
      daddr[c*32 +: 32] = rq_addr[c];
      ccwrite[c] = (rq_rd[c] || rq_wr[c]) ? rq_ccw[c] : ($urandom_range(0, 3) == 0);
      cctrans[c] = 1'($urandom_range(0, 1));
      iREN[c]    = ($urandom_range(0, 2) != 0);
      iaddr[c*32 +: 32]  = $urandom & 32'hFFFF_FFFC;
      dstore[c*32 +: 32] = $urandom;
    end
    ramstate = ($urandom_range(0, 2) == 0) ? ACC : 2'($urandom_range(0, 1));
    ramload  = $urandom;
  endtask

  task automatic compare_cycle;
    bit acc, exp_ren, exp_wen;
    int ic;
    logic [31:0] ea, es;
    logic [CPUS-1:0] eiw, edw, ecw, eci, oth;
    acc = (ramstate == ACC);
    exp_ren = 0; exp_wen = 0; ea = '0; es = '0;
    eiw = '1; edw = '1; ecw = '0; eci = '0;
    ic = (m_words == 0) ? first_from(iREN, m_irr) : -1;
    if (ic >= 0) begin
      exp_ren = 1;
      ea = iaddr[ic*32 +: 32];
      eiw[ic] = !acc;
      check("iload", iload[ic*32 +: 32], ramload);
    end
    oth = '1;
    if (m_owner >= 0) oth[m_owner] = 1'b0;
    if (m_snoop) begin
      ecw = oth;
      if (snoop_ok(ic, acc) && m_rdx) eci = oth;
    end
    if (m_words > 0) begin
      ea = (m_addr & ~32'(WPB * 4 - 1)) + 32'(4 * (WPB - m_words));
      edw[m_owner] = !acc;
      if (m_write) begin
        exp_wen = 1;
        es = dstore[m_owner*32 +: 32];
      end else if (m_src >= 0) begin
        exp_wen = 1;
        es = dstore[m_src*32 +: 32];
        edw[m_src] = !acc;
        ecw[m_src] = 1'b1;
        check("dload_c2c", dload[m_owner*32 +: 32], es);
      end else begin
        exp_ren = 1;
        check("dload_ram", dload[m_owner*32 +: 32], ramload);
      end
    end
    if (m_owner >= 0)
      for (int k = 0; k < CPUS; k++) check("snoopaddr", ccsnoopaddr[k*32 +: 32], m_addr);
    check("ramREN", 32'(ramREN), 32'(exp_ren));
    check("ramWEN", 32'(ramWEN), 32'(exp_wen));
    if (exp_ren || exp_wen) check("ramaddr", ramaddr, ea);
    if (exp_wen) check("ramstore", ramstore, es);
    check("iwait", 32'(iwait), 32'(eiw));
    check("dwait", 32'(dwait), 32'(edw));
    check("ccwait", 32'(ccwait), 32'(ecw));
    check("ccinv", 32'(ccinv), 32'(eci));
  endtask

  task automatic advance_model;
    bit acc;
    int ic, g;
    logic [CPUS-1:0] dreq;
    acc  = (ramstate == ACC);
    ic   = (m_words == 0) ? first_from(iREN, m_irr) : -1;
    dreq = dREN | dWEN;
    if (ic >= 0 && acc) m_irr = (ic + 1) % CPUS;
    if (m_words > 0) begin
      if (acc) begin
        m_words--;
        if (m_words == 0) begin
          if (m_write) rq_wr[m_owner] = 0;
          else         rq_rd[m_owner] = 0;
          m_owner = -1;
          m_src   = -1;
        end
      end
    end else if (m_snoop) begin
      if (snoop_ok(ic, acc)) begin
        m_snoop = 0;
        m_src   = -1;
        for (int k = 0; k < CPUS; k++)
          if (k != m_owner && ccwrite[k] && m_src < 0) m_src = k;
        m_words = WPB;
      end
    end else if (m_arb) begin
      m_arb = 0;
      g = first_from(dreq, m_drr);
      if (g >= 0) begin
        m_owner = g;
        m_write = dWEN[g];
        m_addr  = daddr[g*32 +: 32];
        m_rdx   = ccwrite[g];
        m_drr   = (g + 1) % CPUS;
        if (m_write) begin m_words = WPB; m_src = -1; end
        else m_snoop = 1;
      end
    end else if (|dreq) begin
      m_arb = 1;
    end
  endtask

  task automatic step;
    @(negedge CLK);
    drive_random();
    #1;
    compare_cycle();
    @(posedge CLK);
    advance_model();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ramREN"}, 32'(ramREN), 32'd0);
    check({tag, "_ramWEN"}, 32'(ramWEN), 32'd0);
    check({tag, "_dwait"}, 32'(dwait), 32'((1 << CPUS) - 1));
    check({tag, "_iwait"}, 32'(iwait), 32'((1 << CPUS) - 1));
    check({tag, "_ccwait"}, 32'(ccwait), 32'd0);
    check({tag, "_ccinv"}, 32'(ccinv), 32'd0);
  endtask

  initial begin
    bit in_share;
    nRST = 1'b0;
    drive_zero();
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    @(negedge CLK);
    nRST = 1'b1;

    for (int t = 0; t < 2500; t++) step();

    // Hit reset while a cache-to-cache block sits at its second beat.
    in_share = 0;
    for (int t = 0; t < 4000 && !in_share; t++) begin
      if (m_words == WPB - 1 && m_src >= 0 && !m_write) in_share = 1;
      else step();
    end
    check("share_beat1_reached", 32'(in_share), 32'd1);
    @(negedge CLK);
    nRST = 1'b0;
    drive_zero();
    #1;
    check_reset_outputs("async_rst");
    @(posedge CLK);
    #1;
    check_reset_outputs("rst_edge");
    @(negedge CLK);
    nRST = 1'b1;
    model_reset();

    for (int t = 0; t < 1500; t++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
